// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : time_counter
//  Description : Time-of-day counter. A prescaler divides clk down to a
//                one-second event that drives cascaded seconds, minutes and
//                hours counters. Supports run/pause, validated loading and a
//                12/24-hour display decode.
//  Ports       : clk, reset (sync, active-high)
//                run        - 1 advances time, 0 freezes prescaler/counters
//                mode12     - 12-hour display (only when HOURS_PER_DAY==24)
//                load, load_hour/min/sec - one-cycle time load request
//                sec_o, min_o, hour_o, pm_o - current time
//                sec_tick, min_tick, hour_tick, day_tick - unit pulses
//                load_err   - one-cycle pulse on a rejected load
//  Revision    : 1.0 - initial release
// ============================================================================
module time_counter #(
    parameter int TICKS_PER_SEC = 10000,
    parameter int PRESC_W       = 14,
    parameter int SEC_PER_MIN   = 60,
    parameter int MIN_PER_HOUR  = 60,
    parameter int HOURS_PER_DAY = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode12,
    input  logic       load,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [4:0] hour_o,
    output logic       pm_o,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick,
    output logic       load_err
);

    localparam logic [PRESC_W-1:0] c_P_MAX   = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]         c_SEC_MAX = 6'(SEC_PER_MIN - 1);
    localparam logic [5:0]         c_MIN_MAX = 6'(MIN_PER_HOUR - 1);
    localparam logic [4:0]         c_HR_MAX  = 5'(HOURS_PER_DAY - 1);
    localparam logic [31:0]        c_SPM     = SEC_PER_MIN;
    localparam logic [31:0]        c_MPH     = MIN_PER_HOUR;
    localparam logic [31:0]        c_HPD     = HOURS_PER_DAY;

    logic [PRESC_W-1:0] r_p;
    logic [5:0]         r_sec;
    logic [5:0]         r_min;
    logic [4:0]         r_hr;
    logic               r_sec_tick;
    logic               r_min_tick;
    logic               r_hour_tick;
    logic               r_day_tick;
    logic               r_load_err;

    logic w_load_ok;

    assign w_load_ok = ({27'd0, load_hour} < c_HPD) &&
                       ({26'd0, load_min}  < c_MPH) &&
                       ({26'd0, load_sec}  < c_SPM);

    // Ticks and load_err default low every edge so each is a single-cycle
    // pulse aligned with the counter values it announces.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p         <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_hr        <= '0;
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_day_tick  <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_tick  <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
            r_day_tick  <= 1'b0;
            r_load_err  <= 1'b0;
            if (load) begin
                // A rejected load freezes everything, prescaler included.
                if (w_load_ok) begin
                    r_p   <= '0;
                    r_sec <= load_sec;
                    r_min <= load_min;
                    r_hr  <= load_hour;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (run) begin
                if (r_p == c_P_MAX) begin
                    r_p        <= '0;
                    r_sec_tick <= 1'b1;
                    if (r_sec == c_SEC_MAX) begin
                        r_sec      <= '0;
                        r_min_tick <= 1'b1;
                        if (r_min == c_MIN_MAX) begin
                            r_min       <= '0;
                            r_hour_tick <= 1'b1;
                            if (r_hr == c_HR_MAX) begin
                                r_hr       <= '0;
                                r_day_tick <= 1'b1;
                            end else begin
                                r_hr <= r_hr + 5'd1;
                            end
                        end else begin
                            r_min <= r_min + 6'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 6'd1;
                    end
                end else begin
                    r_p <= r_p + PRESC_W'(1);
                end
            end
        end
    end

    // Hour display decode is combinational so a mode12 change shows at once.
    generate
        if (HOURS_PER_DAY == 24) begin : g_disp_24
            logic       w_pm;
            logic [4:0] w_hr12;
            assign w_pm   = (r_hr >= 5'd12);
            assign w_hr12 = w_pm ? (r_hr - 5'd12) : r_hr;
            assign pm_o   = w_pm;
            assign hour_o = mode12 ? ((w_hr12 == 5'd0) ? 5'd12 : w_hr12) : r_hr;
        end else begin : g_disp_plain
            logic w_unused_mode12;
            assign w_unused_mode12 = mode12;
            assign pm_o            = 1'b0;
            assign hour_o          = r_hr;
        end
    endgenerate

    assign sec_o     = r_sec;
    assign min_o     = r_min;
    assign sec_tick  = r_sec_tick;
    assign min_tick  = r_min_tick;
    assign hour_tick = r_hour_tick;
    assign day_tick  = r_day_tick;
    assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_counter
//  Description : Self-checking bench for time_counter. Three instances:
//                dut_a (TICKS_PER_SEC=4) runs a directed vector table,
//                dut_b (TICKS_PER_SEC=1, 3 s/min, 2 min/h) checks the cascade,
//                dut_c (TICKS_PER_SEC=2, defaults) checks the day rollover.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut_a ----------------
    logic       a_rst = 1'b1, a_run = 1'b0, a_m12 = 1'b0, a_ld = 1'b0;
    logic [4:0] a_lh = '0;
    logic [5:0] a_lm = '0, a_ls = '0;
    logic [5:0] a_sec, a_min;
    logic [4:0] a_hour;
    logic       a_pm, a_st, a_mt, a_ht, a_dt, a_le;

    time_counter #(.TICKS_PER_SEC(4), .PRESC_W(14), .SEC_PER_MIN(60),
                   .MIN_PER_HOUR(60), .HOURS_PER_DAY(24)) dut_a (
        .clk(clk), .reset(a_rst), .run(a_run), .mode12(a_m12), .load(a_ld),
        .load_hour(a_lh), .load_min(a_lm), .load_sec(a_ls),
        .sec_o(a_sec), .min_o(a_min), .hour_o(a_hour), .pm_o(a_pm),
        .sec_tick(a_st), .min_tick(a_mt), .hour_tick(a_ht), .day_tick(a_dt),
        .load_err(a_le));

    // ---------------- dut_b ----------------
    logic       b_rst = 1'b1, b_run = 1'b0;
    logic [5:0] b_sec, b_min;
    logic [4:0] b_hour;
    logic       b_pm, b_st, b_mt, b_ht, b_dt, b_le;

    time_counter #(.TICKS_PER_SEC(1), .PRESC_W(14), .SEC_PER_MIN(3),
                   .MIN_PER_HOUR(2), .HOURS_PER_DAY(24)) dut_b (
        .clk(clk), .reset(b_rst), .run(b_run), .mode12(1'b0), .load(1'b0),
        .load_hour(5'd0), .load_min(6'd0), .load_sec(6'd0),
        .sec_o(b_sec), .min_o(b_min), .hour_o(b_hour), .pm_o(b_pm),
        .sec_tick(b_st), .min_tick(b_mt), .hour_tick(b_ht), .day_tick(b_dt),
        .load_err(b_le));

    // ---------------- dut_c ----------------
    logic       c_rst = 1'b1, c_run = 1'b0, c_m12 = 1'b0, c_ld = 1'b0;
    logic [4:0] c_lh = '0;
    logic [5:0] c_lm = '0, c_ls = '0;
    logic [5:0] c_sec, c_min;
    logic [4:0] c_hour;
    logic       c_pm, c_st, c_mt, c_ht, c_dt, c_le;

    time_counter #(.TICKS_PER_SEC(2), .PRESC_W(14)) dut_c (
        .clk(clk), .reset(c_rst), .run(c_run), .mode12(c_m12), .load(c_ld),
        .load_hour(c_lh), .load_min(c_lm), .load_sec(c_ls),
        .sec_o(c_sec), .min_o(c_min), .hour_o(c_hour), .pm_o(c_pm),
        .sec_tick(c_st), .min_tick(c_mt), .hour_tick(c_ht), .day_tick(c_dt),
        .load_err(c_le));

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // etk packs {day, hour, min, sec} ticks.
    typedef struct {
        bit rst; bit run; bit m12; bit ld;
        int lh;  int lm;  int ls;
        int es;  int em;  int eh;  int epm; int etk; int ele;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    task automatic step_a();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input vec_t v);
        chk({tag, " sec"},  int'(a_sec),  v.es);
        chk({tag, " min"},  int'(a_min),  v.em);
        chk({tag, " hour"}, int'(a_hour), v.eh);
        chk({tag, " pm"},   int'(a_pm),   v.epm);
        chk({tag, " ticks"}, int'({a_dt, a_ht, a_mt, a_st}), v.etk);
        chk({tag, " load_err"}, int'(a_le), v.ele);
    endtask

    initial begin
        //            rst run m12 ld  lh  lm  ls   sec min hr pm tk  le
        vecs[0]  = '{1, 1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0,  0,  0,  0,   1,  0,  0, 0, 1, 0};  // 4th edge
        vecs[6]  = '{0, 1, 0, 0,  0,  0,  0,   1,  0,  0, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0,  0,  0,  0,   1,  0,  0, 0, 0, 0};  // p=2
        vecs[8]  = '{0, 0, 0, 0,  0,  0,  0,   1,  0,  0, 0, 0, 0};  // pause
        vecs[9]  = '{0, 0, 0, 0,  0,  0,  0,   1,  0,  0, 0, 0, 0};
        vecs[10] = '{0, 1, 0, 0,  0,  0,  0,   1,  0,  0, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 0,  0,  0,  0,   2,  0,  0, 0, 1, 0};  // resume +2
        vecs[12] = '{0, 1, 0, 1,  5,  6,  7,   7,  6,  5, 0, 0, 0};  // load
        vecs[13] = '{0, 1, 0, 0,  0,  0,  0,   7,  6,  5, 0, 0, 0};  // p=1
        vecs[14] = '{0, 1, 0, 1, 24, 10, 10,   7,  6,  5, 0, 0, 1};  // bad hr
        vecs[15] = '{0, 1, 0, 0,  0,  0,  0,   7,  6,  5, 0, 0, 0};
        vecs[16] = '{0, 1, 0, 0,  0,  0,  0,   7,  6,  5, 0, 0, 0};
        vecs[17] = '{0, 1, 0, 0,  0,  0,  0,   8,  6,  5, 0, 1, 0};  // p held
        vecs[18] = '{0, 1, 0, 0,  0,  0,  0,   8,  6,  5, 0, 0, 0};
        vecs[19] = '{0, 1, 0, 0,  0,  0,  0,   8,  6,  5, 0, 0, 0};
        vecs[20] = '{0, 1, 0, 0,  0,  0,  0,   8,  6,  5, 0, 0, 0};  // p=3
        vecs[21] = '{0, 1, 1, 1, 13,  0,  0,   0,  0,  1, 1, 0, 0};  // load on wrap
        vecs[22] = '{0, 0, 0, 0,  0,  0,  0,   0,  0, 13, 1, 0, 0};
        vecs[23] = '{0, 0, 1, 1,  0,  0,  0,   0,  0, 12, 0, 0, 0};
        vecs[24] = '{0, 0, 1, 1, 12,  0,  0,   0,  0, 12, 1, 0, 0};
        vecs[25] = '{0, 0, 1, 1, 11,  0,  0,   0,  0, 11, 0, 0, 0};
        vecs[26] = '{0, 0, 1, 1, 11, 59, 60,   0,  0, 11, 0, 0, 1};  // bad sec
        vecs[27] = '{1, 1, 1, 1,  3,  3,  3,   0,  0, 12, 0, 0, 0};  // reset wins
        vecs[28] = '{0, 1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0};

        // ---- table-driven sequence on dut_a ----
        for (int i = 0; i < NV; i++) begin
            a_rst = vecs[i].rst;
            a_run = vecs[i].run;
            a_m12 = vecs[i].m12;
            a_ld  = vecs[i].ld;
            a_lh  = 5'(vecs[i].lh);
            a_lm  = 6'(vecs[i].lm);
            a_ls  = 6'(vecs[i].ls);
            step_a();
            check_a($sformatf("row%0d", i), vecs[i]);
        end

        // ---- dut_a: long pause keeps the partial second ----
        a_run = 1'b1; a_ld = 1'b0; a_rst = 1'b0;
        step_a(); // p=2
        a_run = 1'b0;
        for (int k = 0; k < 10; k++) step_a();
        chk("pause sec", int'(a_sec), 0);
        chk("pause ticks", int'({a_dt, a_ht, a_mt, a_st}), 0);
        a_run = 1'b1;
        step_a();
        chk("resume1 sec_tick", int'(a_st), 0);
        step_a();
        chk("resume2 sec_tick", int'(a_st), 1);
        chk("resume2 sec", int'(a_sec), 1);

        // ---- dut_a: mode12 change visible without a clock edge ----
        a_run = 1'b0; a_ld = 1'b1; a_lh = 5'd13; a_lm = 6'd0; a_ls = 6'd0;
        a_m12 = 1'b0;
        step_a();
        a_ld = 1'b0;
        chk("m12off hour", int'(a_hour), 13);
        a_m12 = 1'b1;
        #1;
        chk("m12on hour", int'(a_hour), 1);
        chk("m12on pm", int'(a_pm), 1);
        a_m12 = 1'b0;
        #1;
        chk("m12off2 hour", int'(a_hour), 13);

        // ---- dut_b: cascade with TICKS_PER_SEC=1 ----
        begin
            int es [6] = '{1, 2, 0, 1, 2, 0};
            int em [6] = '{0, 0, 1, 1, 1, 0};
            int eh [6] = '{0, 0, 0, 0, 0, 1};
            int et [6] = '{1, 1, 3, 1, 1, 7};
            b_run = 1'b1;
            step_a();
            chk("b reset sec_tick", int'(b_st), 0);
            chk("b reset sec", int'(b_sec), 0);
            b_rst = 1'b0;
            for (int k = 0; k < 6; k++) begin
                step_a();
                chk($sformatf("b edge%0d sec", k + 1), int'(b_sec), es[k]);
                chk($sformatf("b edge%0d min", k + 1), int'(b_min), em[k]);
                chk($sformatf("b edge%0d hour", k + 1), int'(b_hour), eh[k]);
                chk($sformatf("b edge%0d ticks", k + 1),
                    int'({b_dt, b_ht, b_mt, b_st}), et[k]);
            end
        end

        // ---- dut_c: day rollover 23:59:59 -> 00:00:00 ----
        step_a();
        c_rst = 1'b0;
        c_m12 = 1'b1;
        c_ld = 1'b1; c_lh = 5'd23; c_lm = 6'd59; c_ls = 6'd59; c_run = 1'b1;
        step_a();
        c_ld = 1'b0;
        chk("c load sec", int'(c_sec), 59);
        chk("c load min", int'(c_min), 59);
        chk("c load hour12", int'(c_hour), 11);
        chk("c load pm", int'(c_pm), 1);
        chk("c load ticks", int'({c_dt, c_ht, c_mt, c_st}), 0);
        step_a();
        chk("c mid ticks", int'({c_dt, c_ht, c_mt, c_st}), 0);
        step_a();
        chk("c roll sec", int'(c_sec), 0);
        chk("c roll min", int'(c_min), 0);
        chk("c roll hour12", int'(c_hour), 12);
        chk("c roll pm", int'(c_pm), 0);
        chk("c roll ticks", int'({c_dt, c_ht, c_mt, c_st}), 15);
        step_a();
        chk("c after ticks", int'({c_dt, c_ht, c_mt, c_st}), 0);
        c_m12 = 1'b0;
        #1;
        chk("c 24h hour", int'(c_hour), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_counter.md
# time_counter

Synthesizable, parametrised time-of-day counter for the TIME_COUNTER block. It replaces the free-running simulation-only hour clock with a single-clock design. A prescaler divides the system clock into a one-second tick, which drives cascaded seconds, minutes and hours counters. The block provides one-cycle unit tick pulses, run/pause control, validated time loading and a 12/24-hour display mode.

## Interface
- TICKS_PER_SEC, 10000, clk cycles per second (100 µs clk); legal range 1..2^PRESC_W
- PRESC_W, 14, prescaler width
- SEC_PER_MIN, 60, seconds per minute; legal range 2..64
- MIN_PER_HOUR, 60, minutes per hour; legal range 2..64
- HOURS_PER_DAY, 24, hours per day; legal range 2..32
- clk  in  1  system clock; all logic runs on its rising edge
- reset  in  1  synchronous, active-high
- run  in  1  1 = time advances; 0 = prescaler and counters hold
- mode12  in  1  1 = 12-hour display on hour_o; only honoured when HOURS_PER_DAY==24
- load  in  1  one-cycle request to load time
- load_hour  in  5  hour to load, 0..HOURS_PER_DAY-1
- load_min  in  6  minute to load
- load_sec  in  6  second to load
- sec_o  out  6  current seconds
- min_o  out  6  current minutes
- hour_o  out  5  current hour, display-formatted
- pm_o  out  1  internal hour ≥ 12; forced 0 when HOURS_PER_DAY≠24
- sec_tick  out  1  one-cycle pulse on each seconds increment
- min_tick  out  1  one-cycle pulse when seconds wrap
- hour_tick  out  1  one-cycle pulse when minutes wrap
- day_tick  out  1  one-cycle pulse when hours wrap
- load_err  out  1  one-cycle pulse when a load is rejected

## Operation
- State registers: prescaler p, sec, min, hr (internal hour 0..HOURS_PER_DAY-1), the four tick flops and load_err.
- Edge priority, highest first: reset > load > advance > hold.
- Reset clears p, sec, min, hr, all ticks and load_err to 0. sec_o, min_o and hr read 0.
- In 12-hour mode after reset, hour_o = 12 and pm_o = 0.
- Load, when load=1:
  - Valid load (load_hour<HOURS_PER_DAY, load_min<MIN_PER_HOUR, load_sec<SEC_PER_MIN): hr/min/sec take the load values and p clears to 0. All tick outputs are 0 in the following cycle, even if p was about to wrap.
  - Invalid load: all state is unchanged, including p, which does not advance that cycle. load_err = 1 for the following cycle only.
  - Load is accepted regardless of run.
- Advance, when run=1 and load=0:
  - If p==TICKS_PER_SEC-1: p←0 and sec increments (a second event). Otherwise p←p+1.
  - On a second event, sec increments. If sec==SEC_PER_MIN-1, sec wraps to 0 and min increments.
  - The same wrap-and-carry rule cascades min→hr (MIN_PER_HOUR-1) and hr→0 (HOURS_PER_DAY-1).
  - Ticks are registered alongside the counter updates: sec_tick on every second event, min_tick on the sec wrap, hour_tick on the min wrap, day_tick on the hr wrap.
  - A full rollover asserts all four ticks in the same cycle.
  - Special case TICKS_PER_SEC==1: a second event occurs every cycle and sec_tick stays high continuously.
- Hold, when run=0: all state is frozen and ticks are 0. The p phase is preserved, so resuming continues the partial second.
- Display:
  - hour_o = hr when mode12=0 or HOURS_PER_DAY≠24.
  - Otherwise hour_o = (hr mod 12 == 0) ? 12 : hr mod 12.
  - hour_o and pm_o are decoded combinationally from the registered hr, so a mode12 change is visible in the same cycle.
- sec_o and min_o are direct register outputs.

## Timing
- Every output except hour_o/pm_o decode changes only at the rising edge of clk.
- From run high, the first sec_tick appears after TICKS_PER_SEC edges, counted from p=0.
- A tick is high in exactly the cycle in which the new counter values are visible.
- Load to visible values: 1 edge. Load to next sec_tick: TICKS_PER_SEC edges after the load edge when run=1.
- Reset asserted mid-second or mid-load wins at that edge. No tick or load_err is emitted in the cycle after reset.
- Back-to-back loads are each evaluated independently.

## Test plan
- Reset: TICKS_PER_SEC=4. Assert reset for 2 cycles with run=1 -> all outputs 0, no ticks. After release, the first sec_tick and sec_o=1 appear on the 4th edge.
- Cascade: TICKS_PER_SEC=1, SEC_PER_MIN=3, MIN_PER_HOUR=2, HOURS_PER_DAY=24, run=1 for 6 cycles -> min_tick at sec wraps 2→0. On the 6th edge hour_tick fires, hr=1, min=0, sec=0.
- Day rollover: defaults, TICKS_PER_SEC=2. Load 23:59:59, run=1 -> 2 edges later 00:00:00, with sec_tick, min_tick, hour_tick and day_tick all high for one cycle.
- Invalid load: load 24:10:10 at time 05:06:07 -> time unchanged, load_err high exactly 1 cycle, p not advanced. Then load 13:00:00 with mode12=1 -> hour_o=1, pm_o=1. Set mode12=0 -> hour_o=13 the same cycle.
- Pause/priority: TICKS_PER_SEC=4, run=1 until p=2, then run=0 for 10 cycles -> no change. Resume -> sec_tick after 2 edges. Assert load together with a wrap edge -> load values win and no tick fires.
- 12h boundaries: load hr=0 -> hour_o=12, pm_o=0. hr=12 -> hour_o=12, pm_o=1. hr=11 -> hour_o=11, pm_o=0.
